// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and helpers for the MEM->WB pipeline register.
//   DEF_LANES / DEF_DATA_W / DEF_REG_AW : default lane count and field widths
//   ZERO_REG                            : hard-wired zero register index
//   lane_lsb()                          : LSB of lane k in a lane-packed bus
package pipe_pkg;

    localparam int unsigned DEF_LANES  = 2;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_AW = 5;
    localparam int unsigned ZERO_REG   = 0;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// pipe_lane_reg: one lane of the MEM->WB register.
// Priority at each edge: flush > stall > load.
//   clk, rst         : clock, asynchronous active-high reset
//   flush            : clear valid/memtoreg/regwrite, data fields hold
//   stall            : hold every field
//   valid_m, memtoreg_m, readdata_m, aluout_m, writereg_m : MEM-stage fields
//   wen_m            : already-qualified register write enable
//   *_w              : registered WB-stage fields
module pipe_lane_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              valid_m,
    input  logic              memtoreg_m,
    input  logic              wen_m,
    input  logic [DATA_W-1:0] readdata_m,
    input  logic [DATA_W-1:0] aluout_m,
    input  logic [REG_AW-1:0] writereg_m,
    output logic              valid_w,
    output logic              memtoreg_w,
    output logic              regwrite_w,
    output logic [DATA_W-1:0] readdata_w,
    output logic [DATA_W-1:0] aluout_w,
    output logic [REG_AW-1:0] writereg_w
);

    logic              valid_q, memtoreg_q, regwrite_q;
    logic [DATA_W-1:0] readdata_q, aluout_q;
    logic [REG_AW-1:0] writereg_q;

    // Control bits: flush turns the lane into a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (!stall) begin
            valid_q    <= valid_m;
            memtoreg_q <= memtoreg_m;
            regwrite_q <= wen_m;
        end
    end

    // Data fields only move on a real load; a flushed bubble keeps stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdata_q <= '0;
            aluout_q   <= '0;
            writereg_q <= '0;
        end else if (!flush && !stall) begin
            readdata_q <= readdata_m;
            aluout_q   <= aluout_m;
            writereg_q <= writereg_m;
        end
    end

    assign valid_w    = valid_q;
    assign memtoreg_w = memtoreg_q;
    assign regwrite_w = regwrite_q;
    assign readdata_w = readdata_q;
    assign aluout_w   = aluout_q;
    assign writereg_w = writereg_q;

endmodule

// File: rtl/pipe_mem_wb_reg.sv
// pipe_mem_wb_reg: parametrised MEM->WB pipeline register for the N-issue core.
//   clk, rst                 : clock, asynchronous active-high reset
//   stall_i, flush_i         : per-lane stall / flush requests
//   valid_m .. writereg_m    : MEM-stage lane fields (lane k at [k*W +: W])
//   valid_w .. writereg_w    : registered WB-stage lane fields
//   result_w                 : per-lane writeback mux (readdata or aluout)
//   retired_cnt              : saturating count of retired instructions
// Lane LANES-1 is the youngest; on a same-cycle destination clash the
// youngest loading writer wins and older lanes lose their write enable.
module pipe_mem_wb_reg
    import pipe_pkg::*;
#(
    parameter int unsigned LANES         = DEF_LANES,
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned REG_AW        = DEF_REG_AW,
    parameter int unsigned SHARED_STALL  = 1,
    parameter int unsigned ZERO_SUPPRESS = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         stall_i,
    input  logic [LANES-1:0]         flush_i,
    input  logic [LANES-1:0]         valid_m,
    input  logic [LANES-1:0]         memtoreg_m,
    input  logic [LANES-1:0]         regwrite_m,
    input  logic [LANES*DATA_W-1:0]  readdata_m,
    input  logic [LANES*DATA_W-1:0]  aluout_m,
    input  logic [LANES*REG_AW-1:0]  writereg_m,
    output logic [LANES-1:0]         valid_w,
    output logic [LANES-1:0]         memtoreg_w,
    output logic [LANES-1:0]         regwrite_w,
    output logic [LANES*DATA_W-1:0]  readdata_w,
    output logic [LANES*DATA_W-1:0]  aluout_w,
    output logic [LANES*REG_AW-1:0]  writereg_w,
    output logic [LANES*DATA_W-1:0]  result_w,
    output logic [CNT_W-1:0]         retired_cnt
);

    localparam logic ZS_EN = (ZERO_SUPPRESS != 0);

    logic [LANES-1:0] st;
    logic [LANES-1:0] load;
    logic [LANES-1:0] waw_kill;
    logic [LANES-1:0] wen;
    logic [LANES-1:0] retire;

    always_comb begin
        st = (SHARED_STALL != 0) ? {LANES{|stall_i}} : stall_i;
    end

    assign load   = ~flush_i & ~st;
    assign retire = load & valid_m;

    // Only a younger lane that actually loads a live write can kill an older one.
    always_comb begin
        waw_kill = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = k + 1; j < LANES; j++) begin
                if (load[j] && valid_m[j] && regwrite_m[j] &&
                    (writereg_m[lane_lsb(j, REG_AW) +: REG_AW] ==
                     writereg_m[lane_lsb(k, REG_AW) +: REG_AW])) begin
                    waw_kill[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned DL = lane_lsb(k, DATA_W);
        localparam int unsigned RL = lane_lsb(k, REG_AW);

        logic is_zero;
        assign is_zero = (writereg_m[RL +: REG_AW] == REG_AW'(ZERO_REG));
        assign wen[k]  = regwrite_m[k] & valid_m[k] & ~waw_kill[k] & ~(ZS_EN & is_zero);

        pipe_lane_reg #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush_i[k]),
            .stall      (st[k]),
            .valid_m    (valid_m[k]),
            .memtoreg_m (memtoreg_m[k]),
            .wen_m      (wen[k]),
            .readdata_m (readdata_m[DL +: DATA_W]),
            .aluout_m   (aluout_m[DL +: DATA_W]),
            .writereg_m (writereg_m[RL +: REG_AW]),
            .valid_w    (valid_w[k]),
            .memtoreg_w (memtoreg_w[k]),
            .regwrite_w (regwrite_w[k]),
            .readdata_w (readdata_w[DL +: DATA_W]),
            .aluout_w   (aluout_w[DL +: DATA_W]),
            .writereg_w (writereg_w[RL +: REG_AW])
        );

        assign result_w[DL +: DATA_W] = memtoreg_w[k] ? readdata_w[DL +: DATA_W]
                                                      : aluout_w[DL +: DATA_W];
    end

    // Retired counter: one extra sum bit catches the wrap, which clamps to all-ones.
    logic [CNT_W:0]   inc_ext;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        inc_ext = '0;
        for (int k = 0; k < LANES; k++) begin
            inc_ext = inc_ext + {{CNT_W{1'b0}}, retire[k]};
        end
        sum   = {1'b0, cnt_q} + inc_ext;
        cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retired_cnt = cnt_q;

endmodule
